// File: rtl/memory_read_check_if.sv
// Bus between the read-back checker and the memory / board.
// The checker drives the memory controls and the result display. The other side
// supplies the start button and the memory read data.
interface memory_read_check_if #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic                         on_button;
    logic [DATA_W-1:0]            data_out;
    logic                         enable;
    logic                         write;
    logic [ADDR_W-1:0]            address;
    logic                         busy;
    logic                         done;
    logic                         pass;
    logic [$clog2(DEPTH+1)-1:0]   err_cnt;
    logic [ADDR_W-1:0]            first_err_addr;
    logic [DATA_W-1:0]            rd_data;

    // Memory / board side: drives the button and the read data.
    modport master (
        output on_button, data_out,
        input  enable, write, address, busy, done, pass, err_cnt, first_err_addr, rd_data
    );

    // Checker side.
    modport slave (
        input  on_button, data_out,
        output enable, write, address, busy, done, pass, err_cnt, first_err_addr, rd_data
    );
endinterface

// File: rtl/memory_read_check.sv
// Read-back checker for the 16x16 memory exercise.
// On a rising edge of on_button it sweeps every address in read mode. It compares
// each returned word with exp(a) = {(a+1){1'b1}}, which saturates to all ones.
// It then reports pass/fail, the error count and the first failing address.
module memory_read_check #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input logic                clk_fnl,
    input logic                rst,
    memory_read_check_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int DRN_W = $clog2(RD_LAT+1) + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t               state;
    logic                 btn_q;
    logic                 enable;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ADDR_W-1:0]    address;
    logic [CNT_W-1:0]     err_cnt;
    logic [ADDR_W-1:0]    first_err_addr;
    logic [DATA_W-1:0]    rd_data;
    logic [DRN_W-1:0]     drn_cnt;

    // Issued addresses travel down this pipe so they line up with data_out.
    logic [RD_LAT-1:0]              vld_pipe;
    logic [RD_LAT-1:0][ADDR_W-1:0]  addr_pipe;

    logic                 start;
    logic                 in_sweep;
    logic                 flush;
    logic                 smp_vld;
    logic                 smp_err;
    logic [ADDR_W-1:0]    smp_addr;

    function automatic logic [DATA_W-1:0] exp_word(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DATA_W; i++) w[i] = (i <= int'(a));
        return w;
    endfunction

    // Start edge, sweep qualification and the compare of the aligned sample.
    always_comb begin
        start    = bus.on_button & ~btn_q;
        in_sweep = (state == READ) || (state == DRAIN);
        // Pipe is emptied whenever no sweep is running, or on an abort.
        // A fast restart then cannot pick up stale samples.
        flush    = !in_sweep || !bus.on_button;
        smp_addr = addr_pipe[RD_LAT-1];
        smp_vld  = in_sweep && bus.on_button && vld_pipe[RD_LAT-1];
        smp_err  = (bus.data_out != exp_word(smp_addr));
    end

    // Address alignment pipe: stage 0 captures what is on the bus this cycle.
    always_ff @(posedge clk_fnl or negedge rst) begin
        if (!rst) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
        end else if (flush) begin
            vld_pipe  <= '0;
        end else begin
            for (int i = RD_LAT-1; i > 0; i--) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
            vld_pipe[0]  <= enable;
            addr_pipe[0] <= address;
        end
    end

    // Sweep FSM with registered outputs and result accumulation.
    always_ff @(posedge clk_fnl or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            btn_q          <= 1'b0;
            enable         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            address        <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            rd_data        <= '0;
            drn_cnt        <= '0;
        end else begin
            btn_q <= bus.on_button;

            if (smp_vld) begin
                rd_data <= bus.data_out;
                if (smp_err) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                    if (err_cnt == '0) first_err_addr <= smp_addr;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= READ;
                        enable         <= 1'b1;
                        busy           <= 1'b1;
                        address        <= '0;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                    end
                end
                READ: begin
                    if (!bus.on_button) begin
                        state          <= IDLE;
                        enable         <= 1'b0;
                        busy           <= 1'b0;
                        address        <= '0;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        rd_data        <= '0;
                    end else if (address == ADDR_W'(DEPTH-1)) begin
                        // Last address has been on the bus for one cycle.
                        state   <= DRAIN;
                        enable  <= 1'b0;
                        address <= '0;
                        drn_cnt <= '0;
                    end else begin
                        address <= address + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (!bus.on_button) begin
                        state          <= IDLE;
                        busy           <= 1'b0;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        rd_data        <= '0;
                    end else if (drn_cnt == DRN_W'(RD_LAT)) begin
                        // The final sample landed on the previous edge, so err_cnt is settled.
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_cnt == '0);
                    end else begin
                        drn_cnt <= drn_cnt + DRN_W'(1);
                    end
                end
                DONE: begin
                    if (start) begin
                        state          <= READ;
                        enable         <= 1'b1;
                        busy           <= 1'b1;
                        address        <= '0;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                    end else if (!bus.on_button) begin
                        state          <= IDLE;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        rd_data        <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.enable         = enable;
    assign bus.write          = 1'b0;
    assign bus.address        = address;
    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.pass           = pass;
    assign bus.err_cnt        = err_cnt;
    assign bus.first_err_addr = first_err_addr;
    assign bus.rd_data        = rd_data;
endmodule

// File: tb/tb_memory_read_check.sv
// Bench for memory_read_check: one instance with RD_LAT=1 and one with RD_LAT=2.
// Both share the button and reset. Each has its own memory model.
module tb_memory_read_check;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];
    logic [DATA_W-1:0] stg_b;

    always #5 clk = ~clk;

    memory_read_check_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
    memory_read_check_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

    memory_read_check #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) u_a (
        .clk_fnl(clk), .rst(rst), .bus(bus_a)
    );
    memory_read_check #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2)) u_b (
        .clk_fnl(clk), .rst(rst), .bus(bus_b)
    );

    // Synchronous memories: one registered stage for a, two for b.
    always @(posedge clk) begin
        if (bus_a.enable) bus_a.data_out <= mem_a[bus_a.address];
        if (bus_b.enable) stg_b <= mem_b[bus_b.address];
        bus_b.data_out <= stg_b;
    end

    function automatic logic [DATA_W-1:0] exp_ref(input int a);
        if (a + 1 >= DATA_W) return {DATA_W{1'b1}};
        return DATA_W'((32'd1 << (a + 1)) - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic fill_good();
        for (int a = 0; a < DEPTH; a++) begin
            mem_a[a] = exp_ref(a);
            mem_b[a] = exp_ref(a);
        end
    endtask

    // Reference result: count of mismatching words and the lowest mismatching address.
    task automatic model(input logic [DATA_W-1:0] m [DEPTH], output int ne, output int fe);
        ne = 0;
        fe = 0;
        for (int a = DEPTH-1; a >= 0; a--) begin
            if (m[a] != exp_ref(a)) begin
                ne++;
                fe = a;
            end
        end
    endtask

    // Full sweep from IDLE. Sample j is taken at the negedge after edge E0+j.
    task automatic sweep();
        int ne_a, fe_a, ne_b, fe_b;
        model(mem_a, ne_a, fe_a);
        model(mem_b, ne_b, fe_b);
        bus_a.on_button = 1'b0;
        bus_b.on_button = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_done", {31'd0, bus_a.done}, 0);
        chk("idle_en", {31'd0, bus_a.enable}, 0);
        bus_a.on_button = 1'b1;
        bus_b.on_button = 1'b1;
        for (int j = 0; j < DEPTH + 4; j++) begin
            @(negedge clk);
            if (j == 0) chk("err_clr", 32'(bus_a.err_cnt), 0);
            if (j < DEPTH) begin
                chk("addr_a", 32'(bus_a.address), j);
                chk("en_a", {31'd0, bus_a.enable}, 1);
                chk("addr_b", 32'(bus_b.address), j);
            end
            if (j == DEPTH) begin
                chk("drain_en", {31'd0, bus_a.enable}, 0);
                chk("drain_busy", {31'd0, bus_a.busy}, 1);
                chk("drain_addr", 32'(bus_a.address), 0);
            end
            if (j == DEPTH + 1) chk("early_done_a", {31'd0, bus_a.done}, 0);
            if (j == DEPTH + 2) begin
                chk("done_a", {31'd0, bus_a.done}, 1);
                chk("busy_a", {31'd0, bus_a.busy}, 0);
                chk("pass_a", {31'd0, bus_a.pass}, (ne_a == 0));
                chk("errcnt_a", 32'(bus_a.err_cnt), ne_a);
                chk("first_a", 32'(bus_a.first_err_addr), fe_a);
                chk("rd_a", 32'(bus_a.rd_data), 32'(mem_a[DEPTH-1]));
                chk("early_done_b", {31'd0, bus_b.done}, 0);
            end
            if (j == DEPTH + 3) begin
                chk("done_b", {31'd0, bus_b.done}, 1);
                chk("pass_b", {31'd0, bus_b.pass}, (ne_b == 0));
                chk("errcnt_b", 32'(bus_b.err_cnt), ne_b);
                chk("first_b", 32'(bus_b.first_err_addr), fe_b);
                chk("rd_b", 32'(bus_b.rd_data), 32'(mem_b[DEPTH-1]));
            end
        end
        repeat (3) @(negedge clk);
        chk("hold_done", {31'd0, bus_a.done}, 1);
        chk("hold_err", 32'(bus_a.err_cnt), ne_a);
    endtask

    initial begin
        bus_a.on_button = 1'b0;
        bus_b.on_button = 1'b0;
        bus_a.data_out  = '0;
        bus_b.data_out  = '0;
        stg_b           = '0;
        fill_good();
        repeat (2) @(negedge clk);
        chk("rst_en", {31'd0, bus_a.enable}, 0);
        chk("rst_busy", {31'd0, bus_a.busy}, 0);
        chk("rst_err", 32'(bus_a.err_cnt), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("write", {31'd0, bus_a.write}, 0);

        // Clean memory, then words 5 and 12 corrupted, then clean again from DONE.
        sweep();
        mem_a[5]  = 16'h0000;
        mem_a[12] = 16'hFFF0;
        sweep();
        fill_good();
        sweep();

        // Abort while address 7 is on the bus; restart immediately afterwards.
        mem_a[6] = 16'h1234;
        mem_b[6] = 16'h1234;
        bus_a.on_button = 1'b0;
        bus_b.on_button = 1'b0;
        repeat (2) @(negedge clk);
        bus_a.on_button = 1'b1;
        bus_b.on_button = 1'b1;
        for (int j = 0; j < 20 && bus_a.address != 4'd7; j++) @(negedge clk);
        chk("abort_at7", 32'(bus_a.address), 7);
        bus_a.on_button = 1'b0;
        bus_b.on_button = 1'b0;
        @(negedge clk);
        chk("abort_en", {31'd0, bus_a.enable}, 0);
        chk("abort_busy", {31'd0, bus_a.busy}, 0);
        chk("abort_done", {31'd0, bus_a.done}, 0);
        chk("abort_busy_b", {31'd0, bus_b.busy}, 0);
        repeat (4) @(negedge clk);
        chk("abort_late_done", {31'd0, bus_a.done}, 0);
        chk("abort_late_err", 32'(bus_b.err_cnt), 0);
        fill_good();
        sweep();

        // Asynchronous reset between edges, with a non-zero error count present.
        mem_a[0] = 16'h0000;
        bus_a.on_button = 1'b0;
        bus_b.on_button = 1'b0;
        repeat (2) @(negedge clk);
        bus_a.on_button = 1'b1;
        bus_b.on_button = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_rst_err", 32'(bus_a.err_cnt), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_en", {31'd0, bus_a.enable}, 0);
        chk("arst_addr", 32'(bus_a.address), 0);
        chk("arst_busy", {31'd0, bus_a.busy}, 0);
        chk("arst_err", 32'(bus_a.err_cnt), 0);
        chk("arst_rd", 32'(bus_a.rd_data), 0);
        bus_a.on_button = 1'b0;
        bus_b.on_button = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        fill_good();

        // Randomized corruption.
        for (int n = 0; n < 8; n++) begin
            for (int a = 0; a < DEPTH; a++) begin
                if ($urandom_range(0, 3) == 0) mem_a[a] = DATA_W'($urandom);
                else mem_a[a] = exp_ref(a);
                if ($urandom_range(0, 4) == 0) mem_b[a] = exp_ref(a) ^ DATA_W'(1 << $urandom_range(0, DATA_W-1));
                else mem_b[a] = exp_ref(a);
            end
            sweep();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
